// File: rtl/racket_ai_ctl.sv
// racket_ai_ctl: computer opponent for the right-hand racket.
// Infers ball approach from successive ball_xpos samples, walks the racket
// toward a clamped target at one pixel per step tick, and passes the second
// player's mouse y through (clamped) when AI mode is off.
// Optional feature: define RACKET_AI_JITTER_EN to add a per-rally random
// target offset from an 8-bit LFSR, making the AI beatable.
module racket_ai_ctl #(
    parameter int RACKET_LENGTH = 80,
    parameter int BALL_DIAMETER = 16,
    parameter int Y_MIN         = 1,
    parameter int Y_MAX         = 686,
    parameter int CENTER_Y      = 343,
    parameter int REACT_X       = 512,
    parameter int DEAD_ZONE     = 4,
    parameter int STEP_EASY     = 131072,
    parameter int STEP_HARD     = 65536
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    input  logic        ai_en,
    input  logic        difficulty,
    input  logic [11:0] mouse_ypos_ext,
    output logic [11:0] racket_ypos,
    output logic        tracking
);

    localparam logic [11:0]        L_Y_MIN    = 12'(Y_MIN);
    localparam logic [11:0]        L_Y_MAX    = 12'(Y_MAX);
    localparam logic [11:0]        L_CENTER_Y = 12'(CENTER_Y);
    localparam logic [11:0]        L_REACT_X  = 12'(REACT_X);
    localparam logic [11:0]        L_MISS_X   = 12'd1006;
    localparam logic signed [13:0] L_T_OFS    = 14'(BALL_DIAMETER / 2 - RACKET_LENGTH / 2);
    localparam logic [12:0]        L_DEAD     = 13'(DEAD_ZONE);
    localparam logic [19:0]        L_EASY     = 20'(STEP_EASY);
    localparam logic [19:0]        L_HARD     = 20'(STEP_HARD);

    typedef enum logic [1:0] {
        S_CENTER = 2'd0,
        S_TRACK  = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_tracking;
    logic [11:0] r_ypos;
    logic [11:0] r_prev_x;
    logic        r_approaching;
    logic [19:0] r_cnt;
    logic [19:0] r_interval;

    logic               w_approaching;
    logic               w_go_track;
    logic               w_count_en;
    logic [19:0]        w_interval;
    logic               w_tick;
    logic signed [13:0] w_jitter;
    logic signed [13:0] w_raw;
    logic [11:0]        w_trk_target;
    logic [11:0]        w_target;
    logic [11:0]        w_mouse_clamped;
    logic [12:0]        w_tgt_ext;
    logic [12:0]        w_pos_ext;

    assign racket_ypos = r_ypos;
    assign tracking    = r_tracking;

    // Approach flag as seen this cycle: rises on increasing x, falls on
    // decreasing x, holds on equal. The FSM uses this so a direction change
    // moves the state one edge after the ball_xpos sample that shows it.
    assign w_approaching = (ball_xpos > r_prev_x) ? 1'b1 :
                           (ball_xpos < r_prev_x) ? 1'b0 : r_approaching;
    assign w_go_track    = ai_en && w_approaching && (ball_xpos >= L_REACT_X);

`ifdef RACKET_AI_JITTER_EN
    logic [7:0] r_lfsr;
    logic [3:0] r_offset;

    // LFSR x^8+x^6+x^5+x^4+1 free-runs; offset is captured on each CENTER->TRACK.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_lfsr   <= 8'hA5;
            r_offset <= 4'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (r_state == S_CENTER && w_go_track)
                r_offset <= r_lfsr[3:0];
        end
    end

    assign w_jitter = $signed({10'd0, r_offset}) - 14'sd8;
`else
    assign w_jitter = 14'sd0;
`endif

    // Ball-derived target: centre racket on ball centre, clamped to the playfield.
    assign w_raw = $signed({2'b00, ball_ypos}) + L_T_OFS + w_jitter;

    // Clamp the tracking target and the manual mouse position.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first) so no latch is inferred.
        w_trk_target = w_raw[11:0];
        if (w_raw < $signed({2'b00, L_Y_MIN}))
            w_trk_target = L_Y_MIN;
        else if (w_raw > $signed({2'b00, L_Y_MAX}))
            w_trk_target = L_Y_MAX;

        w_mouse_clamped = mouse_ypos_ext;
        if (mouse_ypos_ext < L_Y_MIN)
            w_mouse_clamped = L_Y_MIN;
        else if (mouse_ypos_ext > L_Y_MAX)
            w_mouse_clamped = L_Y_MAX;
    end

    assign w_target  = (r_state == S_CENTER) ? L_CENTER_Y : w_trk_target;
    assign w_tgt_ext = {1'b0, w_target};
    assign w_pos_ext = {1'b0, r_ypos};

    // Step period is latched at the start of each period (count 0), so a
    // difficulty change mid-count only affects the following period.
    assign w_count_en = ai_en && (r_state != S_HOLD);
    assign w_interval = (r_cnt == 20'd0) ? (difficulty ? L_HARD : L_EASY) : r_interval;
    assign w_tick     = w_count_en && (r_cnt == w_interval - 20'd1);

    // Approach detector registers: previous x and the held direction flag.
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is
        // synchronous, so it is just the highest-priority branch on the edge.
        if (rst) begin
            r_prev_x      <= 12'd0;
            r_approaching <= 1'b0;
        end else begin
            r_prev_x      <= ball_xpos;
            r_approaching <= w_approaching;
        end
    end

    // Step timer: counts in AI mode outside HOLD, wraps and ticks at interval-1.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cnt      <= 20'd0;
            r_interval <= L_EASY;
        end else if (!w_count_en) begin
            r_cnt      <= 20'd0;
        end else begin
            r_interval <= w_interval;
            r_cnt      <= w_tick ? 20'd0 : r_cnt + 20'd1;
        end
    end

    // Racket position: mouse passthrough in manual mode, one-pixel steps in AI mode.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_ypos <= L_CENTER_Y;
        end else if (!ai_en) begin
            r_ypos <= w_mouse_clamped;
        end else if (w_tick) begin
            if (w_tgt_ext > w_pos_ext + L_DEAD)
                r_ypos <= r_ypos + 12'd1;
            else if (w_tgt_ext + L_DEAD < w_pos_ext)
                r_ypos <= r_ypos - 12'd1;
        end
    end

    // Behaviour FSM with registered tracking flag (1 exactly while in TRACK).
    always_ff @(posedge pclk) begin
        if (rst || !ai_en) begin
            r_state    <= S_CENTER;
            r_tracking <= 1'b0;
        end else begin
            case (r_state)
                S_CENTER: begin
                    if (w_go_track) begin
                        r_state    <= S_TRACK;
                        r_tracking <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (!w_approaching || ball_xpos < L_REACT_X) begin
                        r_state    <= S_CENTER;
                        r_tracking <= 1'b0;
                    end else if (ball_xpos >= L_MISS_X) begin
                        r_state    <= S_HOLD;
                        r_tracking <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!w_approaching || ball_xpos < L_REACT_X) begin
                        r_state    <= S_CENTER;
                        r_tracking <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_CENTER;
                    r_tracking <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_racket_ai_ctl.sv
// Self-checking bench for racket_ai_ctl (default build, no jitter).
// A rule-level reference model tracks mode, step phase and racket position
// from the input stream; each scenario task compares the DUT against it.
module tb_racket_ai_ctl;

    localparam int P_EASY = 8;
    localparam int P_HARD = 4;
    localparam int YMIN   = 1;
    localparam int YMAX   = 686;
    localparam int CY     = 343;
    localparam int RX     = 512;
    localparam int MISS   = 1006;
    localparam int DZ     = 4;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] ball_xpos;
    logic [11:0] ball_ypos;
    logic        ai_en;
    logic        difficulty;
    logic [11:0] mouse_ypos_ext;
    logic [11:0] racket_ypos;
    logic        tracking;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (mode: 0 centre, 1 track, 2 hold).
    int m_ypos  = CY;
    bit m_trk   = 1'b0;
    int m_mode  = 0;
    int m_phase = 0;
    int m_per   = P_EASY;
    int m_prev  = 0;
    bit m_appr  = 1'b0;

    racket_ai_ctl #(
        .STEP_EASY(P_EASY),
        .STEP_HARD(P_HARD)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .ball_xpos     (ball_xpos),
        .ball_ypos     (ball_ypos),
        .ai_en         (ai_en),
        .difficulty    (difficulty),
        .mouse_ypos_ext(mouse_ypos_ext),
        .racket_ypos   (racket_ypos),
        .tracking      (tracking)
    );

    always #5 pclk = ~pclk;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One clock of the behavioural rules, applied to the inputs seen at the edge.
    task automatic model_step();
        int x;
        int tgt;
        int nxt;
        x = int'(ball_xpos);
        if (rst) begin
            m_ypos = CY; m_trk = 1'b0; m_mode = 0; m_phase = 0;
            m_prev = 0;  m_appr = 1'b0;
            return;
        end
        if (!ai_en) begin
            m_ypos  = clampi(int'(mouse_ypos_ext), YMIN, YMAX);
            m_phase = 0;
        end else if (m_mode == 2) begin
            m_phase = 0;
        end else begin
            if (m_phase == 0) m_per = difficulty ? P_HARD : P_EASY;
            m_phase++;
            if (m_phase == m_per) begin
                m_phase = 0;
                tgt = (m_mode == 0) ? CY : clampi(int'(ball_ypos) + 8 - 40, YMIN, YMAX);
                if (tgt > m_ypos + DZ)      m_ypos++;
                else if (tgt + DZ < m_ypos) m_ypos--;
            end
        end
        if (x > m_prev)      m_appr = 1'b1;
        else if (x < m_prev) m_appr = 1'b0;
        m_prev = x;
        nxt = m_mode;
        if (!ai_en)                                      nxt = 0;
        else if (m_mode == 0 && m_appr && x >= RX)       nxt = 1;
        else if (m_mode != 0 && (!m_appr || x < RX))     nxt = 0;
        else if (m_mode == 1 && x >= MISS)               nxt = 2;
        m_mode = nxt;
        m_trk  = (nxt == 1);
    endtask

    always @(posedge pclk) model_step();

    task automatic test_reset();
        rst = 1'b1; ai_en = 1'b1; difficulty = 1'b0;
        ball_xpos = 12'd300; ball_ypos = 12'd300; mouse_ypos_ext = 12'd0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'd343 || tracking !== 1'b0) begin
                n_bad++;
                $display("FAIL reset c%0d: racket_ypos=%0d tracking=%0b, required 343 0",
                         c, racket_ypos, tracking);
            end
        end
    endtask

    task automatic test_manual();
        ai_en = 1'b0; mouse_ypos_ext = 12'd5;
        @(negedge pclk);
        n_cmp++;
        if (racket_ypos !== 12'd5) begin
            n_bad++; $display("FAIL manual_5: racket_ypos=%0d, required 5", racket_ypos);
        end
        mouse_ypos_ext = 12'd900;
        @(negedge pclk);
        n_cmp++;
        if (racket_ypos !== 12'd686) begin
            n_bad++; $display("FAIL manual_clamp_hi: racket_ypos=%0d, required 686", racket_ypos);
        end
        for (int c = 0; c < 30; c++) begin
            mouse_ypos_ext = 12'($urandom_range(0, 4095));
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL manual_rand c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
        end
        mouse_ypos_ext = 12'd343;
        @(negedge pclk);
    endtask

    task automatic test_track();
        logic [11:0] prev_r;
        difficulty = 1'b1; ball_ypos = 12'd500; ball_xpos = 12'd600; ai_en = 1'b1;
        @(negedge pclk);
        ball_xpos = 12'd601;
        prev_r = racket_ypos;
        for (int c = 0; c < 600; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL track c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
            n_cmp++;
            if (racket_ypos > prev_r + 12'd1 || racket_ypos < prev_r) begin
                n_bad++;
                $display("FAIL track_rate c%0d: racket_ypos=%0d after %0d, required +0/+1",
                         c, racket_ypos, prev_r);
            end
            prev_r = racket_ypos;
        end
        n_cmp++;
        if (racket_ypos !== 12'd464 || tracking !== 1'b1) begin
            n_bad++;
            $display("FAIL track_settle: racket_ypos=%0d tracking=%0b, required 464 1",
                     racket_ypos, tracking);
        end
    endtask

    task automatic test_reverse();
        ball_xpos = 12'd700;
        @(negedge pclk);
        ball_xpos = 12'd699;
        @(negedge pclk);
        n_cmp++;
        if (tracking !== 1'b0) begin
            n_bad++; $display("FAIL reverse_untrack: tracking=%0b, required 0", tracking);
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL reverse c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
        end
        n_cmp++;
        if (racket_ypos !== 12'd347) begin
            n_bad++; $display("FAIL reverse_settle: racket_ypos=%0d, required 347", racket_ypos);
        end
    endtask

    task automatic test_clamp_low();
        ball_xpos = 12'd800; ball_ypos = 12'd0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk || racket_ypos < 12'd1) begin
                n_bad++;
                $display("FAIL clamp_low c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
        end
        n_cmp++;
        if (racket_ypos !== 12'd5) begin
            n_bad++; $display("FAIL clamp_low_settle: racket_ypos=%0d, required 5", racket_ypos);
        end
    endtask

    task automatic test_difficulty();
        logic [11:0] prev_r;
        int last_chg;
        int n_chg;
        n_chg = 0; last_chg = 0;
        difficulty = 1'b1; ball_xpos = 12'd900; ball_ypos = 12'd900;
        @(negedge pclk);
        prev_r = racket_ypos;
        for (int c = 0; c < 200; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL difficulty c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
            if (c > 50 && racket_ypos != prev_r) begin
                n_cmp++;
                if (n_chg == 0 && c - 50 > P_HARD) begin
                    n_bad++;
                    $display("FAIL difficulty_old_step: gap=%0d, required <=%0d", c - 50, P_HARD);
                end else if (n_chg > 0 && c - last_chg != P_EASY) begin
                    n_bad++;
                    $display("FAIL difficulty_new_step: gap=%0d, required %0d", c - last_chg, P_EASY);
                end
                n_chg++;
                last_chg = c;
            end
            prev_r = racket_ypos;
            if (c == 50) difficulty = 1'b0;
        end
    endtask

    task automatic test_hold();
        logic [11:0] frozen;
        ball_xpos = 12'd1010;
        @(negedge pclk);
        frozen = racket_ypos;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== frozen || tracking !== 1'b0 || racket_ypos !== 12'(m_ypos)) begin
                n_bad++;
                $display("FAIL hold c%0d: racket_ypos=%0d tracking=%0b, required %0d 0",
                         c, racket_ypos, tracking, frozen);
            end
        end
        ball_xpos = 12'd400;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL hold_exit c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
        end
    endtask

    task automatic test_rst_mid();
        ball_xpos = 12'd700; ball_ypos = 12'd100;
        repeat (20) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        n_cmp++;
        if (racket_ypos !== 12'd343 || tracking !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: racket_ypos=%0d tracking=%0b, required 343 0",
                     racket_ypos, tracking);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int xi;
        int dir;
        xi = 400; dir = 1; ai_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge pclk);
            n_cmp++;
            if (racket_ypos !== 12'(m_ypos) || tracking !== m_trk) begin
                n_bad++;
                $display("FAIL random c%0d: racket_ypos=%0d tracking=%0b, required %0d %0b",
                         c, racket_ypos, tracking, m_ypos, m_trk);
            end
            if ($urandom_range(0, 299) == 0) ai_en = ~ai_en;
            if ($urandom_range(0, 99) == 0) difficulty = ~difficulty;
            if ($urandom_range(0, 63) == 0) dir = -dir;
            xi = clampi(xi + dir * int'($urandom_range(0, 4)), 0, 1100);
            ball_xpos = 12'(xi);
            if ($urandom_range(0, 31) == 0) ball_ypos = 12'($urandom_range(0, 800));
            mouse_ypos_ext = 12'($urandom_range(0, 1023));
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_track();
        test_reverse();
        test_clamp_low();
        test_difficulty();
        test_hold();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
